// File: rtl/edge_bus_arbiter.sv
// Two-channel (Neighbor-ID / FV) SRAM read-port arbiter for the Edge PE array.
// Build option: define ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module edge_bus_arbiter #(
  parameter int NUM_PE    = 4,
  parameter int NODE_ID_W = 7,
  parameter int TAG_W     = $clog2(NUM_PE)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PE-1:0]             pe_req,
  input  logic [2*NUM_PE-1:0]           pe_req_type,
  input  logic [NODE_ID_W*NUM_PE-1:0]   pe_node_id,
  output logic [NUM_PE-1:0]             pe_grant,
  output logic                          nb_req_valid,
  output logic [NODE_ID_W-1:0]          nb_req_node_id,
  output logic [TAG_W-1:0]              nb_req_pe_tag,
  input  logic                          nb_eos,
  output logic                          fv_req_valid,
  output logic [NODE_ID_W-1:0]          fv_req_node_id,
  output logic [TAG_W-1:0]              fv_req_pe_tag,
  input  logic                          fv_eos,
  output logic                          nb_busy,
  output logic                          fv_busy
);

  localparam int NUM_CH = 2;
  localparam int CH_NB  = 0;
  localparam int CH_FV  = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // First eligible index scanning upward from start, wrapping at NUM_PE; MSB flags a hit.
  function automatic logic [TAG_W:0] pick_winner(input logic [NUM_PE-1:0] elig,
                                                 input logic [TAG_W-1:0]  start);
    logic             found;
    logic [TAG_W-1:0] idx;
    int               j;
    found = 1'b0;
    idx   = {TAG_W{1'b0}};
    for (int k = 0; k < NUM_PE; k++) begin
      j = int'(start) + k;
      if (j >= NUM_PE) begin
        j = j - NUM_PE;
      end
      if (!found && elig[j]) begin
        found = 1'b1;
        idx   = TAG_W'(j);
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [TAG_W-1:0] next_ptr(input logic [TAG_W-1:0] w);
    if (w == TAG_W'(NUM_PE - 1)) begin
      return {TAG_W{1'b0}};
    end else begin
      return w + TAG_W'(1);
    end
  endfunction

  state_t                 state_r      [NUM_CH];
  state_t                 state_next_s [NUM_CH];
  logic [TAG_W-1:0]       rr_r         [NUM_CH];
  logic [TAG_W-1:0]       rr_next_s    [NUM_CH];
  logic [NUM_PE-1:0]      elig_s       [NUM_CH];
  logic [TAG_W-1:0]       start_s      [NUM_CH];
  logic                   win_found_s  [NUM_CH];
  logic [TAG_W-1:0]       win_idx_s    [NUM_CH];
  logic [NODE_ID_W-1:0]   win_node_s   [NUM_CH];
  logic                   launch_s     [NUM_CH];
  logic [NUM_PE-1:0]      grant_ch_s   [NUM_CH];
  logic [NUM_CH-1:0]      eos_s;

  assign eos_s = {fv_eos, nb_eos};

  // Per-channel eligibility, winner selection and next-state; eos in BUSY only releases.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      elig_s[c]       = {NUM_PE{1'b0}};
      state_next_s[c] = state_r[c];
      rr_next_s[c]    = rr_r[c];
      launch_s[c]     = 1'b0;
      grant_ch_s[c]   = {NUM_PE{1'b0}};
      for (int i = 0; i < NUM_PE; i++) begin
        elig_s[c][i] = pe_req[i] && (pe_req_type[2*i +: 2] == 2'(c));
      end
`ifdef ARB_FIXED_PRIO_EN
      start_s[c] = {TAG_W{1'b0}};
`else
      start_s[c] = rr_r[c];
`endif
      {win_found_s[c], win_idx_s[c]} = pick_winner(elig_s[c], start_s[c]);
      win_node_s[c] = pe_node_id[int'(win_idx_s[c])*NODE_ID_W +: NODE_ID_W];
      case (state_r[c])
        ST_IDLE: begin
          if (win_found_s[c]) begin
            launch_s[c]                = 1'b1;
            grant_ch_s[c][win_idx_s[c]] = 1'b1;
            state_next_s[c]            = ST_BUSY;
`ifdef ARB_FIXED_PRIO_EN
            rr_next_s[c]               = {TAG_W{1'b0}};
`else
            rr_next_s[c]               = next_ptr(win_idx_s[c]);
`endif
          end else begin
            state_next_s[c] = ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (eos_s[c]) begin
            state_next_s[c] = ST_IDLE;
          end else begin
            state_next_s[c] = ST_BUSY;
          end
        end
        default: begin
          state_next_s[c] = ST_IDLE;
        end
      endcase
    end
  end

  // State, pointers and all outputs are registered; command fields hold between launches.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_r[c] <= ST_IDLE;
        rr_r[c]    <= {TAG_W{1'b0}};
      end
      pe_grant       <= {NUM_PE{1'b0}};
      nb_req_valid   <= 1'b0;
      nb_req_node_id <= {NODE_ID_W{1'b0}};
      nb_req_pe_tag  <= {TAG_W{1'b0}};
      fv_req_valid   <= 1'b0;
      fv_req_node_id <= {NODE_ID_W{1'b0}};
      fv_req_pe_tag  <= {TAG_W{1'b0}};
      nb_busy        <= 1'b0;
      fv_busy        <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_r[c] <= state_next_s[c];
        rr_r[c]    <= rr_next_s[c];
      end
      pe_grant     <= grant_ch_s[CH_NB] | grant_ch_s[CH_FV];
      nb_req_valid <= launch_s[CH_NB];
      fv_req_valid <= launch_s[CH_FV];
      if (launch_s[CH_NB]) begin
        nb_req_node_id <= win_node_s[CH_NB];
        nb_req_pe_tag  <= win_idx_s[CH_NB];
      end
      if (launch_s[CH_FV]) begin
        fv_req_node_id <= win_node_s[CH_FV];
        fv_req_pe_tag  <= win_idx_s[CH_FV];
      end
      nb_busy <= (state_next_s[CH_NB] == ST_BUSY);
      fv_busy <= (state_next_s[CH_FV] == ST_BUSY);
    end
  end

endmodule

// File: doc/edge_bus_arbiter.md
# edge_bus_arbiter

Shares the Neighbor-ID SRAM read port and the FV SRAM read port among NUM_PE Edge PEs. Each PE raises a typed read request with a target node ID. Per channel, the arbiter picks one requester, returns a one-cycle grant to it, and issues a one-cycle read command tagged with the winner's PE tag. The channel then stays locked until that SRAM signals end-of-stream. The block sits between the Edge PE array and the two SRAM read controllers.

## Interface
Parameters:
- NUM_PE, 4: number of Edge PE requesters (≥2).
- NODE_ID_W, 7: node ID width.
- TAG_W, $clog2(NUM_PE): PE tag width.

Ports:
- clk  in  1  global clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- pe_req  in  NUM_PE  per-PE request, held until granted.
- pe_req_type  in  2*NUM_PE  per-PE type:
  - 0 = Neighbor-ID read.
  - 1 = FV read.
  - 2 and 3 = invalid.
- pe_node_id  in  NODE_ID_W*NUM_PE  per-PE node ID; PE i occupies slice [i*NODE_ID_W +: NODE_ID_W].
- pe_grant  out  NUM_PE  one-cycle grant pulse, at most one bit per channel.
- nb_req_valid  out  1  Neighbor-ID SRAM read command, one-cycle pulse.
- nb_req_node_id  out  NODE_ID_W  node ID for the nb command.
- nb_req_pe_tag  out  TAG_W  winning PE index for the nb command.
- nb_eos  in  1  Neighbor-ID SRAM end-of-stream.
- fv_req_valid  out  1  FV SRAM read command, one-cycle pulse.
- fv_req_node_id  out  NODE_ID_W  node ID for the fv command.
- fv_req_pe_tag  out  TAG_W  winning PE index for the fv command.
- fv_eos  in  1  FV SRAM end-of-stream.
- nb_busy  out  1  Neighbor-ID channel locked.
- fv_busy  out  1  FV channel locked.

## Operation
- Two independent channels, NB (type 0) and FV (type 1). Each has:
  - a 2-state FSM: IDLE, BUSY;
  - a round-robin pointer rr_c of TAG_W bits.
- Channel c is eligible for PE i when pe_req[i] is high and pe_req_type[i] equals c.
- Requests with type 2 or 3 are never granted and never affect rr_c.
- IDLE, at least one eligible requester:
  - Winner w is the first eligible index found by scanning rr_c, rr_c+1, … modulo NUM_PE.
  - Registered outputs: pe_grant[w]=1, c_req_valid=1, c_req_node_id=pe_node_id[w], c_req_pe_tag=w.
  - rr_c updates to (w+1) mod NUM_PE, wrapping from NUM_PE-1 to 0.
  - FSM moves to BUSY.
- IDLE, no eligible requester: outputs stay 0 and state is unchanged.
- BUSY:
  - No grants on this channel.
  - c_eos high moves the FSM to IDLE.
  - c_req_node_id and c_req_pe_tag hold their last values.
- c_eos while IDLE is ignored.
- pe_grant is the OR of both channels' grant vectors. One PE never wins both channels in the same cycle, because its single type selects one channel.
- A request whose type changes while waiting is re-evaluated each cycle against its current type.

## Timing
- Reset clears everything: all outputs 0, both FSMs IDLE, rr_nb=rr_fv=0. An in-flight stream is abandoned and no eos is awaited.
- Request latency: request sampled at edge t makes pe_grant and c_req_valid high for exactly the cycle after edge t, i.e. one cycle.
- nb_busy and fv_busy are high from the grant cycle until the cycle after c_eos is sampled.
- Release and re-arbitration:
  - c_eos sampled at edge t puts the channel in IDLE after edge t.
  - The earliest next grant on that channel is after edge t+1.
  - There is no same-cycle bypass.
- Simultaneous events: eos and new requests in the same cycle give release only, no grant.
- NB and FV may grant in the same cycle, to two different PEs.
- The granted PE drops pe_req on the cycle it sees pe_grant. The channel is BUSY by then, so no double grant can occur.

## Configuration
- ARB_FIXED_PRIO_EN:
  - Defined: winner is the lowest eligible index; rr_nb and rr_fv are held at 0.
  - Undefined (default): round-robin as described above.
- All other behaviour and timing are identical in both builds.

## Test plan
- Single request, PE2 type 0, node 0x15 →
  - One cycle later: pe_grant=0100, nb_req_valid=1, node 0x15, tag 2.
  - nb_busy=1 until one cycle after nb_eos.
- Contention, PE0/PE1/PE3 all requesting type 1 from reset →
  - Grants go to PE0, PE1, PE3, in that order.
  - Each follows the previous fv_eos by 2 cycles.
  - rr_fv ends at 0 (wrap).
- PE0 type 0 and PE1 type 1 requesting in the same cycle → pe_grant=0011, both req_valid high in the same cycle.
- nb_eos coincident with a pending PE3 type-0 request → no grant that cycle; PE3 granted the next cycle.
- PE1 requests type 2 → no grant and no req_valid for 20 cycles.
- Reset during BUSY, then PE0 request → nb_busy=0 immediately and the request is granted without an eos. With ARB_FIXED_PRIO_EN, PE0 and PE2 contending → PE0 wins repeatedly.
